// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module   : load_store_unit
// Purpose  : Sequential load/store unit with byte/half/word lanes, sign/zero
//            extension, misaligned split into two word accesses, bus timeout.
// Revision : 1.0
// ============================================================================
module load_store_unit #(
    parameter int ADDR_W      = 32,
    parameter bit MISALIGN_EN = 1'b1,
    parameter int TIMEOUT     = 16
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              lsu_valid_i,
    output logic              lsu_ready_o,
    input  logic [3:0]        op_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [31:0]       wdata_i,
    output logic              done_o,
    output logic [31:0]       rdata_o,
    output logic              err_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [3:0]        mem_be_o,
    output logic [31:0]       mem_wdata_o,
    input  logic              mem_ack_i,
    input  logic [31:0]       mem_rdata_i
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ACC1 = 2'd1;
    localparam logic [1:0] S_ACC2 = 2'd2;
    localparam logic [1:0] S_RESP = 2'd3;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    localparam int               CNT_W     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int               TO_LAST_I = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
    localparam logic [CNT_W-1:0] TO_LAST   = TO_LAST_I[CNT_W-1:0];

    typedef struct packed {
        logic       legal;
        logic       mem;
        logic       load;
        logic       sext;
        logic [1:0] size;
    } dec_t;

    function automatic dec_t f_decode(input logic [3:0] op);
        dec_t d;
        d = '0;
        d.legal = 1'b1;
        case (op)
            4'b1000: begin d.mem = 1'b1; d.load = 1'b1; d.sext = 1'b1; d.size = SZ_B; end
            4'b1001: begin d.mem = 1'b1; d.load = 1'b1; d.sext = 1'b1; d.size = SZ_H; end
            4'b1010: begin d.mem = 1'b1; d.load = 1'b1; d.sext = 1'b1; d.size = SZ_W; end
            4'b1100: begin d.mem = 1'b1; d.load = 1'b1; d.size = SZ_B; end
            4'b1101: begin d.mem = 1'b1; d.load = 1'b1; d.size = SZ_H; end
            4'b1011: begin d.mem = 1'b1; d.size = SZ_B; end
            4'b1110: begin d.mem = 1'b1; d.size = SZ_H; end
            4'b1111: begin d.mem = 1'b1; d.size = SZ_W; end
            default: d.legal = ~op[3];
        endcase
        return d;
    endfunction

    function automatic logic f_misal(input logic [1:0] size, input logic [1:0] off);
        return ((size == SZ_H) && (off == 2'd3)) || ((size == SZ_W) && (off != 2'd0));
    endfunction

    logic [1:0]        state_q, state_d;
    logic              load_q, store_q, sext_q, split_q, err_q;
    logic [1:0]        size_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [31:0]       rbuf_lo_q, rbuf_hi_q;
    logic [CNT_W-1:0]  cnt_q;

    dec_t              w_dec;
    logic              w_misal, w_direct, w_in_err, w_accept, w_in_acc, w_to_hit;
    logic [1:0]        w_off;
    logic [3:0]        w_mask;
    logic [7:0]        w_be8;
    logic [63:0]       w_wd64;
    logic [31:0]       w_rword, w_ext;
    logic [ADDR_W-3:0] w_word, w_word_nxt;

    assign w_dec    = f_decode(op_i);
    assign w_misal  = f_misal(w_dec.size, addr_i[1:0]);
    assign w_in_err = ~w_dec.legal | (w_dec.mem & w_misal & ~MISALIGN_EN);
    assign w_direct = ~w_dec.legal | ~w_dec.mem | (w_misal & ~MISALIGN_EN);
    assign w_accept = lsu_valid_i & (state_q == S_IDLE);
    assign w_in_acc = (state_q == S_ACC1) || (state_q == S_ACC2);
    assign w_to_hit = (TIMEOUT != 0) && (cnt_q == TO_LAST);

    // Lane placement: an 8-lane window spanning the addressed word and the next one.
    assign w_off      = addr_q[1:0];
    assign w_be8      = {4'b0000, w_mask} << w_off;
    assign w_wd64     = {32'd0, wdata_q} << {w_off, 3'b000};
    assign w_rword    = 32'({rbuf_hi_q, rbuf_lo_q} >> {w_off, 3'b000});
    assign w_word     = addr_q[ADDR_W-1:2];
    assign w_word_nxt = w_word + (ADDR_W-2)'(1);

    always_comb begin
        w_mask = 4'b0000;
        case (size_q)
            SZ_B:    w_mask = 4'b0001;
            SZ_H:    w_mask = 4'b0011;
            SZ_W:    w_mask = 4'b1111;
            default: w_mask = 4'b0000;
        endcase
    end

    always_comb begin
        w_ext = w_rword;
        case (size_q)
            SZ_B:    w_ext = {{24{sext_q & w_rword[7]}}, w_rword[7:0]};
            SZ_H:    w_ext = {{16{sext_q & w_rword[15]}}, w_rword[15:0]};
            default: w_ext = w_rword;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (lsu_valid_i) begin
                    state_d = w_direct ? S_RESP : S_ACC1;
                end
            end
            S_ACC1: begin
                if (mem_ack_i) begin
                    state_d = split_q ? S_ACC2 : S_RESP;
                end else if (w_to_hit) begin
                    state_d = S_RESP;
                end
            end
            S_ACC2: begin
                if (mem_ack_i || w_to_hit) begin
                    state_d = S_RESP;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        lsu_ready_o = 1'b0;
        done_o      = 1'b0;
        rdata_o     = 32'd0;
        err_o       = 1'b0;
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_be_o    = 4'b0000;
        mem_wdata_o = 32'd0;
        case (state_q)
            S_IDLE: lsu_ready_o = 1'b1;
            S_ACC1: begin
                mem_req_o   = 1'b1;
                mem_we_o    = store_q;
                mem_addr_o  = {w_word, 2'b00};
                mem_be_o    = w_be8[3:0];
                mem_wdata_o = store_q ? w_wd64[31:0] : 32'd0;
            end
            S_ACC2: begin
                mem_req_o   = 1'b1;
                mem_we_o    = store_q;
                mem_addr_o  = {w_word_nxt, 2'b00};
                mem_be_o    = w_be8[7:4];
                mem_wdata_o = store_q ? w_wd64[63:32] : 32'd0;
            end
            S_RESP: begin
                done_o  = 1'b1;
                err_o   = err_q;
                rdata_o = (load_q && !err_q) ? w_ext : 32'd0;
            end
            default: lsu_ready_o = 1'b0;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            load_q    <= 1'b0;
            store_q   <= 1'b0;
            sext_q    <= 1'b0;
            split_q   <= 1'b0;
            err_q     <= 1'b0;
            size_q    <= SZ_B;
            addr_q    <= '0;
            wdata_q   <= 32'd0;
            rbuf_lo_q <= 32'd0;
            rbuf_hi_q <= 32'd0;
            cnt_q     <= '0;
        end else begin
            // Counter restarts on every state change, so each ACC state gets a full budget.
            if (state_q != state_d) begin
                cnt_q <= '0;
            end else if (w_in_acc) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
            if (w_accept) begin
                load_q    <= w_dec.mem & w_dec.load;
                store_q   <= w_dec.mem & ~w_dec.load;
                sext_q    <= w_dec.sext;
                size_q    <= w_dec.size;
                split_q   <= w_dec.mem & w_misal & MISALIGN_EN;
                err_q     <= w_in_err;
                addr_q    <= addr_i;
                wdata_q   <= wdata_i;
                rbuf_lo_q <= 32'd0;
                rbuf_hi_q <= 32'd0;
            end
            if ((state_q == S_ACC1) && mem_ack_i) begin
                rbuf_lo_q <= mem_rdata_i;
            end
            if ((state_q == S_ACC2) && mem_ack_i) begin
                rbuf_hi_q <= mem_rdata_i;
            end
            if (w_in_acc && !mem_ack_i && w_to_hit) begin
                err_q <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_load_store_unit
// Purpose  : Directed self-checking bench for load_store_unit.
// Revision : 1.0
// ============================================================================
module tb_load_store_unit;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        lsu_valid_i, valid_b;
    logic [3:0]  op_i;
    logic [31:0] addr_i, wdata_i;
    logic        mem_ack_i;
    logic [31:0] mem_rdata_i;

    logic        lsu_ready_o, done_o, err_o, mem_req_o, mem_we_o;
    logic [31:0] rdata_o, mem_addr_o, mem_wdata_o;
    logic [3:0]  mem_be_o;

    logic        b_ready, b_done, b_err, b_req, b_we;
    logic [31:0] b_rdata, b_addr, b_wdata;
    logic [3:0]  b_be;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk_i = ~clk_i;

    load_store_unit #(.ADDR_W(32), .MISALIGN_EN(1'b1), .TIMEOUT(4)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .lsu_valid_i(lsu_valid_i), .lsu_ready_o(lsu_ready_o),
        .op_i(op_i), .addr_i(addr_i), .wdata_i(wdata_i), .done_o(done_o), .rdata_o(rdata_o),
        .err_o(err_o), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o), .mem_ack_i(mem_ack_i),
        .mem_rdata_i(mem_rdata_i)
    );

    load_store_unit #(.ADDR_W(32), .MISALIGN_EN(1'b0), .TIMEOUT(4)) dut_b (
        .clk_i(clk_i), .rst_ni(rst_ni), .lsu_valid_i(valid_b), .lsu_ready_o(b_ready),
        .op_i(op_i), .addr_i(addr_i), .wdata_i(wdata_i), .done_o(b_done), .rdata_o(b_rdata),
        .err_o(b_err), .mem_req_o(b_req), .mem_we_o(b_we), .mem_addr_o(b_addr),
        .mem_be_o(b_be), .mem_wdata_o(b_wdata), .mem_ack_i(mem_ack_i),
        .mem_rdata_i(mem_rdata_i)
    );

    task automatic tick();
        @(negedge clk_i);
    endtask

    // Present a request at the current negedge; returns at the negedge of cycle 1.
    task automatic issue(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wd);
        op_i = op; addr_i = addr; wdata_i = wd; lsu_valid_i = 1'b1;
        tick();
        lsu_valid_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        tick(); tick();
        n_cmp++; if (lsu_ready_o !== 1'b1) begin n_err++; $display("FAIL rst_ready got %b exp 1", lsu_ready_o); end
        n_cmp++; if ({done_o, err_o, mem_req_o, mem_we_o} !== 4'b0000) begin n_err++; $display("FAIL rst_ctrl got %b exp 0000", {done_o, err_o, mem_req_o, mem_we_o}); end
        n_cmp++; if ({rdata_o, mem_addr_o, mem_wdata_o, mem_be_o} !== 100'd0) begin n_err++; $display("FAIL rst_data got %h exp 0", {rdata_o, mem_addr_o, mem_wdata_o, mem_be_o}); end
        rst_ni = 1'b1;
        tick();
    endtask

    task automatic test_lw();
        issue(4'b1010, 32'h0000_0100, 32'd0);
        n_cmp++; if ({mem_req_o, mem_we_o, mem_be_o} !== 6'b10_1111) begin n_err++; $display("FAIL lw_req got %b exp 101111", {mem_req_o, mem_we_o, mem_be_o}); end
        n_cmp++; if (mem_addr_o !== 32'h0000_0100) begin n_err++; $display("FAIL lw_addr got %h exp 00000100", mem_addr_o); end
        tick(); tick();
        n_cmp++; if ({done_o, mem_req_o} !== 2'b01) begin n_err++; $display("FAIL lw_wait got %b exp 01", {done_o, mem_req_o}); end
        mem_ack_i = 1'b1; mem_rdata_i = 32'hDEAD_BEEF;
        tick();
        mem_ack_i = 1'b0;
        n_cmp++; if ({done_o, err_o, mem_req_o} !== 3'b100) begin n_err++; $display("FAIL lw_done got %b exp 100", {done_o, err_o, mem_req_o}); end
        n_cmp++; if (rdata_o !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL lw_rdata got %h exp deadbeef", rdata_o); end
        tick();
        n_cmp++; if ({lsu_ready_o, done_o} !== 2'b10) begin n_err++; $display("FAIL lw_idle got %b exp 10", {lsu_ready_o, done_o}); end
    endtask

    // Single-access load returning the extended value of a given memory word.
    task automatic load1(input string nm, input logic [3:0] op, input logic [31:0] addr,
                         input logic [31:0] word, input logic [3:0] exp_be, input logic [31:0] exp_rd);
        issue(op, addr, 32'd0);
        n_cmp++; if (mem_be_o !== exp_be) begin n_err++; $display("FAIL %s_be got %b exp %b", nm, mem_be_o, exp_be); end
        mem_ack_i = 1'b1; mem_rdata_i = word;
        tick();
        mem_ack_i = 1'b0;
        n_cmp++; if ({done_o, rdata_o} !== {1'b1, exp_rd}) begin n_err++; $display("FAIL %s_rdata got %b/%h exp 1/%h", nm, done_o, rdata_o, exp_rd); end
        tick();
    endtask

    task automatic test_load_ext();
        load1("lb",  4'b1000, 32'h103, 32'h8012_3456, 4'b1000, 32'hFFFF_FF80);
        load1("lbu", 4'b1100, 32'h103, 32'h8012_3456, 4'b1000, 32'h0000_0080);
        load1("lh",  4'b1001, 32'h102, 32'h8001_7777, 4'b1100, 32'hFFFF_8001);
        load1("lhu", 4'b1101, 32'h102, 32'h8001_7777, 4'b1100, 32'h0000_8001);
    endtask

    task automatic test_store();
        issue(4'b1110, 32'h0000_0102, 32'h0000_1234);
        n_cmp++; if ({mem_req_o, mem_we_o, mem_be_o} !== 6'b11_1100) begin n_err++; $display("FAIL sh_ctrl got %b exp 111100", {mem_req_o, mem_we_o, mem_be_o}); end
        n_cmp++; if ({mem_addr_o, mem_wdata_o} !== {32'h100, 32'h1234_0000}) begin n_err++; $display("FAIL sh_data got %h/%h exp 00000100/12340000", mem_addr_o, mem_wdata_o); end
        mem_ack_i = 1'b1;
        tick();
        mem_ack_i = 1'b0;
        n_cmp++; if ({done_o, err_o, mem_req_o, rdata_o} !== {3'b100, 32'd0}) begin n_err++; $display("FAIL sh_done got %b%b%b/%h exp 100/0", done_o, err_o, mem_req_o, rdata_o); end
        tick();
        issue(4'b1011, 32'h0000_0101, 32'h0000_00AB);
        n_cmp++; if ({mem_be_o, mem_wdata_o} !== {4'b0010, 32'h0000_AB00}) begin n_err++; $display("FAIL sb_lane got %b/%h exp 0010/0000ab00", mem_be_o, mem_wdata_o); end
        mem_ack_i = 1'b1;
        tick();
        mem_ack_i = 1'b0;
        tick();
    endtask

    task automatic test_split();
        issue(4'b1111, 32'h0000_0101, 32'hAABB_CCDD);
        n_cmp++; if ({mem_addr_o, mem_be_o, mem_wdata_o} !== {32'h100, 4'b1110, 32'hBBCC_DD00}) begin n_err++; $display("FAIL sw1 got %h/%b/%h exp 00000100/1110/bbccdd00", mem_addr_o, mem_be_o, mem_wdata_o); end
        mem_ack_i = 1'b1;
        tick();
        n_cmp++; if ({done_o, mem_req_o, mem_we_o} !== 3'b011) begin n_err++; $display("FAIL sw2_ctrl got %b exp 011", {done_o, mem_req_o, mem_we_o}); end
        n_cmp++; if ({mem_addr_o, mem_be_o, mem_wdata_o} !== {32'h104, 4'b0001, 32'h0000_00AA}) begin n_err++; $display("FAIL sw2 got %h/%b/%h exp 00000104/0001/000000aa", mem_addr_o, mem_be_o, mem_wdata_o); end
        tick();
        mem_ack_i = 1'b0;
        n_cmp++; if ({done_o, err_o} !== 2'b10) begin n_err++; $display("FAIL sw_done got %b exp 10", {done_o, err_o}); end
        tick();
        // Split word load across 0x100/0x104
        issue(4'b1010, 32'h0000_0102, 32'd0);
        n_cmp++; if (mem_be_o !== 4'b1100) begin n_err++; $display("FAIL lw_split1_be got %b exp 1100", mem_be_o); end
        mem_ack_i = 1'b1; mem_rdata_i = 32'h4433_2211;
        tick();
        n_cmp++; if (mem_be_o !== 4'b0011) begin n_err++; $display("FAIL lw_split2_be got %b exp 0011", mem_be_o); end
        mem_rdata_i = 32'h8877_6655;
        tick();
        mem_ack_i = 1'b0;
        n_cmp++; if ({done_o, rdata_o} !== {1'b1, 32'h6655_4433}) begin n_err++; $display("FAIL lw_split got %b/%h exp 1/66554433", done_o, rdata_o); end
        tick();
        // Split signed half at offset 3
        issue(4'b1001, 32'h0000_0103, 32'd0);
        mem_ack_i = 1'b1; mem_rdata_i = 32'h7F00_0000;
        tick();
        mem_rdata_i = 32'h0000_00FF;
        tick();
        mem_ack_i = 1'b0;
        n_cmp++; if ({done_o, rdata_o} !== {1'b1, 32'hFFFF_FF7F}) begin n_err++; $display("FAIL lh_split got %b/%h exp 1/ffffff7f", done_o, rdata_o); end
        tick();
        // Second word wraps to address 0
        issue(4'b1111, 32'hFFFF_FFFE, 32'h1122_3344);
        n_cmp++; if ({mem_addr_o, mem_be_o, mem_wdata_o} !== {32'hFFFF_FFFC, 4'b1100, 32'h3344_0000}) begin n_err++; $display("FAIL wrap1 got %h/%b/%h exp fffffffc/1100/33440000", mem_addr_o, mem_be_o, mem_wdata_o); end
        mem_ack_i = 1'b1;
        tick();
        n_cmp++; if ({mem_addr_o, mem_be_o, mem_wdata_o} !== {32'h0, 4'b0011, 32'h0000_1122}) begin n_err++; $display("FAIL wrap2 got %h/%b/%h exp 00000000/0011/00001122", mem_addr_o, mem_be_o, mem_wdata_o); end
        tick();
        mem_ack_i = 1'b0;
        tick();
    endtask

    task automatic test_direct();
        issue(4'b0000, 32'h0000_0103, 32'd0);
        n_cmp++; if ({done_o, err_o, mem_req_o, rdata_o} !== {3'b100, 32'd0}) begin n_err++; $display("FAIL noop got %b%b%b/%h exp 100/0", done_o, err_o, mem_req_o, rdata_o); end
        tick();
        op_i = 4'b1001; addr_i = 32'h0000_0103; valid_b = 1'b1;
        tick();
        valid_b = 1'b0;
        n_cmp++; if ({b_done, b_err, b_req, b_rdata} !== {3'b110, 32'd0}) begin n_err++; $display("FAIL flag_misal got %b%b%b/%h exp 110/0", b_done, b_err, b_req, b_rdata); end
        tick();
        n_cmp++; if ({b_ready, b_done} !== 2'b10) begin n_err++; $display("FAIL flag_idle got %b exp 10", {b_ready, b_done}); end
    endtask

    task automatic test_timeout();
        issue(4'b1010, 32'h0000_0200, 32'd0);
        tick(); tick(); tick();
        n_cmp++; if ({mem_req_o, done_o} !== 2'b10) begin n_err++; $display("FAIL to_held got %b exp 10", {mem_req_o, done_o}); end
        tick();
        n_cmp++; if ({mem_req_o, done_o, err_o, rdata_o} !== {3'b011, 32'd0}) begin n_err++; $display("FAIL to_err got %b%b%b/%h exp 011/0", mem_req_o, done_o, err_o, rdata_o); end
        mem_ack_i = 1'b1;
        tick();
        mem_ack_i = 1'b0;
        n_cmp++; if ({lsu_ready_o, done_o, mem_req_o} !== 3'b100) begin n_err++; $display("FAIL to_late_ack got %b exp 100", {lsu_ready_o, done_o, mem_req_o}); end
        // Timeout in the second half of a split store
        issue(4'b1111, 32'h0000_0101, 32'hAABB_CCDD);
        mem_ack_i = 1'b1;
        tick();
        mem_ack_i = 1'b0;
        tick(); tick(); tick();
        n_cmp++; if ({mem_req_o, mem_addr_o} !== {1'b1, 32'h104}) begin n_err++; $display("FAIL to2_held got %b/%h exp 1/00000104", mem_req_o, mem_addr_o); end
        tick();
        n_cmp++; if ({mem_req_o, done_o, err_o} !== 3'b011) begin n_err++; $display("FAIL to2_err got %b exp 011", {mem_req_o, done_o, err_o}); end
        tick();
    endtask

    task automatic test_reset_mid();
        issue(4'b1010, 32'h0000_0300, 32'd0);
        n_cmp++; if (mem_req_o !== 1'b1) begin n_err++; $display("FAIL rmid_req got %b exp 1", mem_req_o); end
        #2 rst_ni = 1'b0;
        #1;
        n_cmp++; if ({mem_req_o, lsu_ready_o, done_o} !== 3'b010) begin n_err++; $display("FAIL rmid_async got %b exp 010", {mem_req_o, lsu_ready_o, done_o}); end
        tick();
        rst_ni = 1'b1;
        tick();
        n_cmp++; if ({mem_req_o, lsu_ready_o, done_o} !== 3'b010) begin n_err++; $display("FAIL rmid_after got %b exp 010", {mem_req_o, lsu_ready_o, done_o}); end
    endtask

    task automatic test_back_to_back();
        op_i = 4'b1100; addr_i = 32'h0000_0100; lsu_valid_i = 1'b1;
        tick();
        // Requester keeps valid high and changes the request while the unit is busy
        op_i = 4'b0000;
        n_cmp++; if ({lsu_ready_o, mem_req_o, mem_be_o} !== 6'b01_0001) begin n_err++; $display("FAIL b2b_busy got %b exp 010001", {lsu_ready_o, mem_req_o, mem_be_o}); end
        mem_ack_i = 1'b1; mem_rdata_i = 32'h0000_00C3;
        tick();
        mem_ack_i = 1'b0;
        n_cmp++; if ({done_o, lsu_ready_o, rdata_o} !== {2'b10, 32'h0000_00C3}) begin n_err++; $display("FAIL b2b_first got %b%b/%h exp 10/000000c3", done_o, lsu_ready_o, rdata_o); end
        tick();
        n_cmp++; if (lsu_ready_o !== 1'b1) begin n_err++; $display("FAIL b2b_ready got %b exp 1", lsu_ready_o); end
        tick();
        lsu_valid_i = 1'b0;
        n_cmp++; if ({done_o, err_o, mem_req_o, rdata_o} !== {3'b100, 32'd0}) begin n_err++; $display("FAIL b2b_second got %b%b%b/%h exp 100/0", done_o, err_o, mem_req_o, rdata_o); end
        tick();
    endtask

    initial begin
        rst_ni = 1'b0; lsu_valid_i = 1'b0; valid_b = 1'b0;
        op_i = 4'b0000; addr_i = 32'd0; wdata_i = 32'd0;
        mem_ack_i = 1'b0; mem_rdata_i = 32'd0;
        test_reset();
        test_lw();
        test_load_ext();
        test_store();
        test_split();
        test_direct();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
